// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_sched
// Description : Round-robin scheduler sharing one registered ones-count-mod-3
//               Mealy detector among NREQ requesters. A granted WIDTH-bit job
//               word is shifted LSB-first into the detector. The detector's
//               output pulses are counted and returned with the requester ID.
//
// Parameters  : NREQ  - number of requesters (>= 2)
//               WIDTH - bits per job word (>= 2)
//
// Ports       : clk, rst          - clock (rising edge), synchronous active-high reset
//               req[NREQ]         - level requests, held until granted
//               req_data          - job words, requester i at [i*WIDTH +: WIDTH]
//               gnt[NREQ]         - one-hot grant pulse
//               busy              - job in progress
//               done              - one-cycle result strobe
//               done_id/done_count- result of the finished job (held)
//               det_clr_n, det_x  - detector clear (active low) and serial input
//               det_y             - detector registered output
//               abort/done_abort  - only with SEQ_DET_SCHED_ABORT_EN defined
//
// Optional    : `define SEQ_DET_SCHED_ABORT_EN adds the abort input and the
//               done_abort result flag.
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [CW-1:0]         done_count,
    output logic                  det_clr_n,
    output logic                  det_x,
`ifdef SEQ_DET_SCHED_ABORT_EN
    input  logic                  abort,
    output logic                  done_abort,
`endif
    input  logic                  det_y
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_MAX  = CW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_done;
    logic [IDW-1:0]    r_done_id;
    logic [CW-1:0]     r_done_count;
    logic              r_det_clr_n;
    logic              r_det_x;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [WIDTH-1:0]  r_shift;
    logic [BW-1:0]     r_bit;
    logic [CW-1:0]     r_cnt;

    logic              w_abort;
    logic              w_abort_hit;
    logic              w_start;
    logic              w_found;
    logic [IDW-1:0]    w_idx;
    logic [IDW-1:0]    w_win;
    logic              w_sample;
    logic [CW-1:0]     w_cnt_nxt;
    logic [WIDTH-1:0]  w_words [NREQ];

`ifdef SEQ_DET_SCHED_ABORT_EN
    logic              r_done_abort;
    assign w_abort    = abort;
    assign done_abort = r_done_abort;
`else
    assign w_abort    = 1'b0;
`endif

    // Unpack the flat job-word bus into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign w_words[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Abort only matters while a job is actually using the detector.
    assign w_abort_hit = w_abort &&
                         ((r_state == S_CLEAR) || (r_state == S_SHIFT) || (r_state == S_DRAIN));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bit == c_LAST_BIT) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = (|req) ? S_CLEAR : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort_hit) begin
            w_state_nxt = S_DONE;
        end
    end

    // CLEAR is entered only from IDLE/DONE with a request pending.
    assign w_start = (w_state_nxt == S_CLEAR);

    // ------------------------------------------------------------------------
    // Round-robin search starting one past the last winner.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pulse counting. det_y during SHIFT cycle 0 is still the detector's
    // reset value, so sampling starts at the edge ending SHIFT cycle 1 and
    // the last sample (for the final bit) lands at the edge ending DRAIN.
    // ------------------------------------------------------------------------
    assign w_sample = det_y &&
                      (((r_state == S_SHIFT) && (r_bit != '0)) || (r_state == S_DRAIN));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == S_CLEAR) begin
            w_cnt_nxt = '0;
        end else if (w_sample && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs, all derived from the next state so
    // they line up with the state they describe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= '0;
            r_done_count <= '0;
            r_det_clr_n  <= 1'b0;
            r_det_x      <= 1'b0;
            r_ptr        <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_cnt        <= '0;
`ifdef SEQ_DET_SCHED_ABORT_EN
            r_done_abort <= 1'b0;
`endif
        end else begin
            r_gnt <= '0;
            if (w_start) begin
                r_gnt[w_win] <= 1'b1;
                r_ptr        <= w_win;
                r_id         <= w_win;
                r_shift      <= w_words[w_win];
            end else if (w_state_nxt == S_SHIFT) begin
                r_shift <= r_shift >> 1;
            end

            r_det_x     <= (w_state_nxt == S_SHIFT) ? r_shift[0] : 1'b0;
            r_det_clr_n <= (w_state_nxt != S_CLEAR);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);

            if (r_state == S_SHIFT) begin
                r_bit <= r_bit + BW'(1);
            end else begin
                r_bit <= '0;
            end

            r_cnt <= w_cnt_nxt;

            if (w_state_nxt == S_DONE) begin
                r_done_count <= w_cnt_nxt;
                r_done_id    <= r_id;
`ifdef SEQ_DET_SCHED_ABORT_EN
                r_done_abort <= w_abort_hit;
`endif
            end
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign done_count = r_done_count;
    assign det_clr_n  = r_det_clr_n;
    assign det_x      = r_det_x;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_sched
// Description : Self-checking bench for seq_det_sched. Contains a behavioural
//               ones-count-mod-3 detector driving det_y, a directed vector
//               table, random jobs, round-robin and reset/abort sequences.
//               Abort checks are built when SEQ_DET_SCHED_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CW-1:0]         done_count;
    logic                  det_clr_n;
    logic                  det_x;
    logic                  det_y;
`ifdef SEQ_DET_SCHED_ABORT_EN
    logic                  abort;
    logic                  done_abort;
`endif

    always #5 clk = ~clk;

    seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .done_count (done_count),
        .det_clr_n  (det_clr_n),
        .det_x      (det_x),
`ifdef SEQ_DET_SCHED_ABORT_EN
        .abort      (abort),
        .done_abort (done_abort),
`endif
        .det_y      (det_y)
    );

    // Behavioural detector: registered output is 1 when the running
    // ones count (including the current bit) is divisible by 3.
    logic [1:0] m_cnt;
    logic [1:0] m_nxt;
    logic       m_y;
    assign m_nxt = (m_cnt == 2'd2) ? (det_x ? 2'd0 : 2'd2) : (m_cnt + {1'b0, det_x});
    always @(posedge clk) begin
        if (!det_clr_n) begin
            m_cnt <= 2'd0;
            m_y   <= 1'b1;
        end else begin
            m_cnt <= m_nxt;
            m_y   <= (m_nxt == 2'd0);
        end
    end
    assign det_y = m_y;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_count(input logic [7:0] w);
        int c = 0;
        int n = 0;
        for (int k = 0; k < 8; k++) begin
            c = (c + int'(w[k])) % 3;
            if (c == 0) n++;
        end
        return n;
    endfunction

    // Presents a request at the current cycle, then follows the job through
    // CLEAR, SHIFT, DRAIN and DONE checking every cycle's outputs.
    task automatic run_job(input logic [3:0] rq, input logic [31:0] data,
                           input int id, input logic [7:0] word, input int cnt);
        logic [3:0] g;
        g     = '0;
        g[id] = 1'b1;
        req      = rq;
        req_data = data;
        step();
        check("gnt", 32'(gnt), 32'(g));
        check("busy_clear", 32'(busy), 32'd1);
        check("clr_n_low", 32'(det_clr_n), 32'd0);
        req = '0;
        for (int k = 0; k < WIDTH; k++) begin
            step();
            check("det_x", 32'(det_x), 32'(word[k]));
            check("clr_n_high", 32'(det_clr_n), 32'd1);
        end
        step();
        check("drain_x", 32'(det_x), 32'd0);
        check("drain_done", 32'(done), 32'd0);
        step();
        check("done", 32'(done), 32'd1);
        check("done_id", 32'(done_id), 32'(id));
        check("done_count", 32'(done_count), 32'(cnt));
`ifdef SEQ_DET_SCHED_ABORT_EN
        check("done_abort_norm", 32'(done_abort), 32'd0);
`endif
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] data;
        int          id;
        logic [7:0]  word;
        int          cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_0000, 0, 8'h00, 8};
        vecs[1] = '{4'b0100, 32'h00FF_0000, 2, 8'hFF, 2};
        vecs[2] = '{4'b1000, 32'h0700_0000, 3, 8'h07, 6};
        vecs[3] = '{4'b0010, 32'h0000_AA00, 1, 8'hAA, 3};
        vecs[4] = '{4'b0001, 32'h0000_0055, 0, 8'h55, 2};
        vecs[5] = '{4'b0110, 32'h0011_2200, 1, 8'h22, 1};
        vecs[6] = '{4'b0110, 32'h0011_2200, 2, 8'h11, 0};

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
`ifdef SEQ_DET_SCHED_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_det_x", 32'(det_x), 32'd0);
        check("rst_clr_n", 32'(det_clr_n), 32'd0);
`ifdef SEQ_DET_SCHED_ABORT_EN
        check("rst_done_abort", 32'(done_abort), 32'd0);
`endif
        rst = 1'b0;

        // Directed table, jobs back to back through DONE->CLEAR.
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].rq, vecs[i].data, vecs[i].id, vecs[i].word, vecs[i].cnt);
        end
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_gnt", 32'(gnt), 32'd0);
        check("held_count", 32'(done_count), 32'd0);

        // Random words against the reference count.
        for (int n = 0; n < 200; n++) begin
            int          id;
            logic [7:0]  w;
            logic [31:0] d;
            id = int'($urandom_range(0, 3));
            w  = 8'($urandom);
            d  = $urandom;
            d[id*8 +: 8] = w;
            run_job(4'(1 << id), d, id, w, ref_count(w));
        end

        // Round robin: 4'b1010 held from reset, then 4'b1111.
        rst      = 1'b1;
        req      = 4'b1010;
        req_data = '0;
        repeat (2) step();
        rst = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            logic [3:0] eg;
            logic       ed;
            int         eid;
            step();
            eg  = '0;
            ed  = 1'b0;
            eid = 0;
            case (c)
                1:  eg = 4'b0010;
                12: eg = 4'b1000;
                23: eg = 4'b0001;
                34: eg = 4'b0010;
                45: eg = 4'b0100;
                56: eg = 4'b1000;
                default: eg = '0;
            endcase
            case (c)
                11: begin ed = 1'b1; eid = 1; end
                22: begin ed = 1'b1; eid = 3; end
                33: begin ed = 1'b1; eid = 0; end
                44: begin ed = 1'b1; eid = 1; end
                55: begin ed = 1'b1; eid = 2; end
                66: begin ed = 1'b1; eid = 3; end
                default: begin ed = 1'b0; eid = 0; end
            endcase
            check("rr_gnt", 32'(gnt), 32'(eg));
            check("rr_done", 32'(done), 32'(ed));
            if (ed) begin
                check("rr_done_id", 32'(done_id), 32'(eid));
                check("rr_done_count", 32'(done_count), 32'd8);
            end
            if (c == 22) req = 4'b1111;
            if (c == 66) req = 4'b0000;
        end
        step();
        check("rr_idle_busy", 32'(busy), 32'd0);

        // Reset during SHIFT cycle 4 of a job from requester 2.
        req      = 4'b0100;
        req_data = 32'h00FF_0000;
        step();
        check("mid_gnt", 32'(gnt), 32'b0100);
        req = '0;
        repeat (5) step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_clr_n", 32'(det_clr_n), 32'd0);
        check("mid_rst_count", 32'(done_count), 32'd0);
        rst = 1'b0;
        // Pointer is back at NREQ-1, so requester 1 beats requester 3.
        run_job(4'b1010, 32'hFF00_0000, 1, 8'h00, 8);

`ifdef SEQ_DET_SCHED_ABORT_EN
        // Abort in SHIFT cycle 3 of an all-zero word.
        step();
        req      = 4'b0001;
        req_data = '0;
        step();
        check("ab_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_done", 32'(done), 32'd1);
        check("ab_done_abort", 32'(done_abort), 32'd1);
        check("ab_done_count", 32'(done_count), 32'd3);
        check("ab_busy", 32'(busy), 32'd1);
        step();
        check("ab_after_done", 32'(done), 32'd0);
        check("ab_after_busy", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
